// File: rtl/program_display.sv
// program_display: maps the program counter to a saturated program-region
// number and shows it as two time-multiplexed active-low seven-segment
// digits, blanking the display for a fixed time after every change.
module program_display #(
  parameter int REGION_WORDS = 512,
  parameter int NUM_PROGRAMS = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        freeze,
  output logic [6:0]  prog_num,
  output logic        changed,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic [1:0]  digit
);

  localparam int          SHIFT      = $clog2(REGION_WORDS);
  localparam logic [31:0] MAX_IDX    = 32'(NUM_PROGRAMS - 1);
  localparam int          SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int          BLINK_W    = $clog2(BLINK_CYCLES + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES);
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_t;

  logic [31:0]        idx_raw;
  logic [6:0]         next_prog;
  logic               load;
  logic [SCAN_W-1:0]  scan_cnt;
  slot_t              sel;
  logic [BLINK_W-1:0] blink_cnt;
  logic [6:0]         tens;
  logic [6:0]         units;
  logic [6:0]         seg_next;
  logic [1:0]         digit_next;
  logic [6:0]         seg_q;

  // Active-low {a..g} pattern for one decimal digit; anything else is blank.
  function automatic logic [6:0] glyph(input logic [6:0] v);
    case (v)
      7'd0:    glyph = 7'b0000001;
      7'd1:    glyph = 7'b1001111;
      7'd2:    glyph = 7'b0010010;
      7'd3:    glyph = 7'b0000110;
      7'd4:    glyph = 7'b1001100;
      7'd5:    glyph = 7'b0100100;
      7'd6:    glyph = 7'b0100000;
      7'd7:    glyph = 7'b0001111;
      7'd8:    glyph = 7'b0000000;
      7'd9:    glyph = 7'b0000100;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // Region index from the PC, clamped to the last program instead of wrapping.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch so no latch is inferred.
    idx_raw   = pc >> SHIFT;
    next_prog = MAX_IDX[6:0];
    if (idx_raw < MAX_IDX) next_prog = idx_raw[6:0];
    load      = !freeze && (next_prog != prog_num);
  end

  // Program register and its one-cycle change pulse; freeze holds the value.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      prog_num <= 7'd0;
      changed  <= 1'b0;
    end else begin
      changed <= load;
      if (!freeze) prog_num <= next_prog;
    end
  end

  // Digit-slot timer: SCAN_DIV cycles per slot, alternating units and tens.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt <= '0;
      sel      <= SLOT_UNITS;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      sel      <= (sel == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blanking timer, loaded alongside the change pulse so the outputs go dark
  // on the very next registered cycle; a further change restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt <= '0;
    end else if (load) begin
      blink_cnt <= BLINK_LOAD;
    end else if (blink_cnt != '0) begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  // Pick the glyph and digit enable for the current slot, or blank everything.
  always_comb begin
    tens       = prog_num / 7'd10;
    units      = prog_num % 7'd10;
    seg_next   = SEG_BLANK;
    digit_next = 2'b11;
    if (blink_cnt == '0) begin
      if (sel == SLOT_UNITS) begin
        digit_next = 2'b10;
        seg_next   = glyph(units);
      end else begin
        digit_next = 2'b01;
        seg_next   = (prog_num < 7'd10) ? SEG_BLANK : glyph(tens);
      end
    end
  end

  // Registered display pins so the board sees glitch-free drives.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      digit <= 2'b11;
    end else begin
      seg_q <= seg_next;
      digit <= digit_next;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_program_display.sv
// tb_program_display: drives two configurations of program_display with the
// same inputs and compares every cycle against a cycle-count reference model.
module tb_program_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 10;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                                        7'b0000110, 7'b1001100, 7'b0100100,
                                        7'b0100000, 7'b0001111, 7'b0000000,
                                        7'b0000100};

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        freeze;

  logic [6:0] prog_a, prog_b;
  logic       chg_a, chg_b;
  logic [6:0] seg_a, seg_b;
  logic [1:0] dig_a, dig_b;

  program_display #(.REGION_WORDS(512), .NUM_PROGRAMS(4),
                    .SCAN_DIV(SCAN), .BLINK_CYCLES(BLINK)) dut_a (
    .clock(clock), .reset(reset), .pc(pc), .freeze(freeze),
    .prog_num(prog_a), .changed(chg_a),
    .a(seg_a[6]), .b(seg_a[5]), .c(seg_a[4]), .d(seg_a[3]),
    .e(seg_a[2]), .f(seg_a[1]), .g(seg_a[0]), .digit(dig_a)
  );

  program_display #(.REGION_WORDS(256), .NUM_PROGRAMS(16),
                    .SCAN_DIV(SCAN), .BLINK_CYCLES(BLINK)) dut_b (
    .clock(clock), .reset(reset), .pc(pc), .freeze(freeze),
    .prog_num(prog_b), .changed(chg_b),
    .a(seg_b[6]), .b(seg_b[5]), .c(seg_b[4]), .d(seg_b[3]),
    .e(seg_b[2]), .f(seg_b[1]), .g(seg_b[0]), .digit(dig_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: region shift and program count per configuration.
  int          shift_cfg [2] = '{9, 8};
  int          nprog_cfg [2] = '{4, 16};
  int          m_prog    [2];
  logic        m_chg     [2];
  logic [6:0]  m_seg     [2];
  logic [1:0]  m_dig     [2];
  int          since_chg [2];
  int          run_edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge with the inputs present at that edge.
  task automatic model_edge(input logic rst, input logic [31:0] pcv, input logic frz);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_prog[i]    = 0;
        m_chg[i]     = 1'b0;
        m_seg[i]     = BLANK;
        m_dig[i]     = 2'b11;
        since_chg[i] = 1000;
      end else begin
        longint unsigned target;
        // Display reflects the state just before this edge.
        if (since_chg[i] < BLINK) begin
          m_seg[i] = BLANK;
          m_dig[i] = 2'b11;
        end else if (((run_edges / SCAN) % 2) == 0) begin
          m_dig[i] = 2'b10;
          m_seg[i] = GLYPH[m_prog[i] % 10];
        end else begin
          m_dig[i] = 2'b01;
          m_seg[i] = (m_prog[i] < 10) ? BLANK : GLYPH[m_prog[i] / 10];
        end
        target = longint'(pcv) >> shift_cfg[i];
        if (target > longint'(nprog_cfg[i] - 1)) target = longint'(nprog_cfg[i] - 1);
        if (!frz && int'(target) != m_prog[i]) begin
          m_chg[i]     = 1'b1;
          since_chg[i] = 0;
        end else begin
          m_chg[i] = 1'b0;
          if (since_chg[i] < 1000) since_chg[i]++;
        end
        if (!frz) m_prog[i] = int'(target);
      end
    end
    run_edges = rst ? 0 : run_edges + 1;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge(reset, pc, freeze);
    #1;
    check("a_program", 32'(prog_a), 32'(m_prog[0]));
    check("a_changed", 32'(chg_a),  32'(m_chg[0]));
    check("a_segs",    32'(seg_a),  32'(m_seg[0]));
    check("a_digit",   32'(dig_a),  32'(m_dig[0]));
    check("b_program", 32'(prog_b), 32'(m_prog[1]));
    check("b_changed", 32'(chg_b),  32'(m_chg[1]));
    check("b_segs",    32'(seg_b),  32'(m_seg[1]));
    check("b_digit",   32'(dig_b),  32'(m_dig[1]));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    run_edges = 0;
    reset  = 1'b1;
    pc     = 32'd0;
    freeze = 1'b0;

    // Reset and idle scanning of program 0.
    run(2);
    reset = 1'b0;
    run(12);

    // Region change into program 1, then blanking and redisplay.
    pc = 32'd600;
    run(16);

    // Saturation at the top of the address space, then back down without wrap.
    pc = 32'hFFFF_FFFF;
    run(16);
    pc = 32'h0000_0200;
    run(16);

    // Two-digit value on the 16-program configuration.
    pc = 32'd3077;
    run(20);

    // Freeze ignores a PC move; releasing it loads the pending value.
    pc = 32'd0;
    run(14);
    freeze = 1'b1;
    pc     = 32'd1024;
    run(6);
    freeze = 1'b0;
    run(14);

    // Reset three cycles into a blanking period.
    pc = 32'd0;
    run(14);
    pc = 32'd1024;
    run(3);
    reset = 1'b1;
    pc    = 32'd0;
    run(2);
    reset = 1'b0;
    run(10);

    // Randomized traffic: held PCs, region hops, freezes and occasional resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       pc = 32'($urandom_range(0, 20) * 256 + $urandom_range(0, 255));
          1:       pc = $urandom();
          2:       pc = 32'hFFFF_FFFF;
          default: pc = 32'd0;
        endcase
      end
      freeze = ($urandom_range(0, 4) == 0);
      reset  = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset  = 1'b0;
    freeze = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_display.md
# program_display

Parametrised, clocked program-number indicator for the board's seven-segment display. It divides the 32-bit program counter into fixed-size program regions and converts the region index into a saturated program number. The number is shown as two time-multiplexed decimal digits, and the display blanks for a fixed time whenever the number changes. It sits between the CPU's PC register and the board display pins.

## Interface

Parameters:
- REGION_WORDS, 512: size of one program region in PC units; must be a power of two, at least 1.
- NUM_PROGRAMS, 4: number of regions, 1..100; the index saturates at NUM_PROGRAMS-1.
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least 1.
- BLINK_CYCLES, 25000000: length of the blanking period after a change; must be at least 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current program counter.
- freeze  in  1  high: hold `program`, no index updates.
- program  out  7  registered program number, 0..NUM_PROGRAMS-1.
- changed  out  1  one-cycle pulse when `program` takes a new value.
- a, b, c, d, e, f, g  out  1 each  segment drives, active-low, registered.
- digit  out  2  digit enables, active-low, registered; digit[0] = units, digit[1] = tens.

## Operation

- **Index:**
  - idx_raw = pc >> log2(REGION_WORDS), compared at full 32-bit width.
  - next = min(idx_raw, NUM_PROGRAMS-1). No wrap-around; pc = 0xFFFFFFFF gives NUM_PROGRAMS-1.
- **Program register:**
  - Each cycle with reset = 0 and freeze = 0: program <= next.
  - With freeze = 1: program holds.
- **changed:**
  - High for exactly the cycle after program is loaded with a value different from its old value.
  - Never asserted by reset, and never asserted while frozen.
- **Scan:**
  - Counter runs 0..SCAN_DIV-1; at the terminal count it wraps to 0 and toggles sel.
  - sel = 0 selects units; sel = 1 selects tens.
- **Blink:**
  - When changed is asserted, the blink counter loads BLINK_CYCLES, then decrements to 0.
  - A new change during blinking reloads the counter.
  - While the blink counter is nonzero: digit = 2'b11 and segments = 7'b1111111.
- **Digit drive (blink counter 0):**
  - sel = 0: digit = 2'b10, segments = units glyph of program.
  - sel = 1: digit = 2'b01, segments = tens glyph. If program < 10, the tens position is blanked (7'b1111111).
- **Glyphs, {a..g}, active-low:**
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- **Decimal split:** tens = program / 10, units = program % 10 (program ≤ 99).
- **Reset values:**
  - program = 0, changed = 0, sel = 0.
  - Scan counter = 0, blink counter = 0.
  - digit = 2'b11, segments = 7'b1111111.
- **Reset mid-blink:** the blink counter is cleared, no pulse is generated, and the display resumes on the units slot.

## Timing

- pc to program: 1 cycle.
- program to changed: the pulse occurs in the same cycle as the new program value is visible.
- State to segment/digit outputs: 1 registered cycle.
  - First cycle after reset release: digit = 2'b10, units "0".
- Digit slot length: exactly SCAN_DIV cycles; the tens/units period is 2*SCAN_DIV.
- Blanking: starts 1 cycle after changed and lasts BLINK_CYCLES cycles measured at the outputs.
- The scan counter keeps running during blinking and during freeze.
- Simultaneous events:
  - freeze = 1 with a pc change: the change is ignored, no pulse.
  - Releasing freeze: next is loaded the following edge, with a pulse if it differs from the held value.

## Test plan

Bench configuration: SCAN_DIV = 4 and BLINK_CYCLES = 10 unless stated.

- **Reset:** reset high 2 cycles with pc = 0.
  - During reset: digit = 11, segments = 1111111.
  - After release: digit alternates 10/01 every 4 cycles; units = 0000001, tens = 1111111; changed stays 0.
- **Region change:** pc goes 0 -> 600.
  - program = 1 one cycle later, with a single changed pulse.
  - Outputs dark for 10 cycles, then units = 1001111.
- **Saturation:** pc = 0xFFFFFFFF with NUM_PROGRAMS = 4.
  - program = 3, units = 0000110; pc = 0x00000200 then gives program = 1, no wrap.
- **Two digits:** NUM_PROGRAMS = 16, REGION_WORDS = 256, pc = 3077.
  - program = 12; tens slot = 1001111, units slot = 0010010.
- **Freeze:** freeze = 1, pc changes 0 -> 1024.
  - program stays 0, no pulse.
  - After freeze drops: program = 2 next cycle, one changed pulse.
- **Reset mid-blink:** reset asserted 3 cycles into blinking.
  - program = 0 and blanking is aborted.
  - After release: units "0" shown with no changed pulse.
